rv_rtype_issue: RTL and testbench

- Issue/writeback stage that feeds the RV32I R-type ALU.
- Accepts 32-bit instructions over a valid/ready handshake and decodes opcode, funct3 and funct7 into the 4-bit ALU op code.
- Reads operands from a 32x32 register file with x0 hardwired to zero, forwards in-flight results, presents operands to the ALU, and writes the ALU result back.
- Sits between instruction fetch and the combinational ALU.

---
 rtl/rv_rtype_issue_if.sv | 35 +++
 rtl/rv_rtype_issue.sv | 147 ++++++++++++++
 tb/tb_rv_rtype_issue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_rtype_issue_if.sv
// Handshake, ALU, writeback and debug signals of the RV32I R-type issue stage.
// The slave modport is the issue stage; the master modport is the surrounding fetch/ALU/debug logic.
interface rv_rtype_issue_if #(
   parameter int XLEN = 32
);
   logic [31:0]     i_instr;
   logic            i_valid;
   logic            o_ready;
   logic            i_hold;
   logic [XLEN-1:0] o_alu_a;
   logic [XLEN-1:0] o_alu_b;
   logic [3:0]      o_alu_op;
   logic [XLEN-1:0] i_alu_res;
   logic            o_wb_valid;
   logic [4:0]      o_wb_rd;
   logic [XLEN-1:0] o_wb_data;
   logic            o_illegal;
   logic [31:0]     o_retired;
   logic            i_dbg_we;
   logic [4:0]      i_dbg_addr;
   logic [XLEN-1:0] i_dbg_wdata;
   logic [XLEN-1:0] o_dbg_rdata;

   modport slave (
      input  i_instr, i_valid, i_hold, i_alu_res, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      output o_ready, o_alu_a, o_alu_b, o_alu_op, o_wb_valid, o_wb_rd, o_wb_data,
             o_illegal, o_retired, o_dbg_rdata
   );

   modport master (
      output i_instr, i_valid, i_hold, i_alu_res, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      input  o_ready, o_alu_a, o_alu_b, o_alu_op, o_wb_valid, o_wb_rd, o_wb_data,
             o_illegal, o_retired, o_dbg_rdata
   );
endinterface

// File: rtl/rv_rtype_issue.sv
// RV32I R-type issue/writeback stage: decode, register file read with forwarding,
// operand presentation to an external combinational ALU, and result writeback.
module rv_rtype_issue #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   rv_rtype_issue_if.slave   bus
);
   localparam logic [6:0] OPC_OP = 7'b0110011;

   logic [XLEN-1:0] regs [NREGS];

   logic [6:0]      opc_p0;
   logic [6:0]      f7_p0;
   logic [2:0]      f3_p0;
   logic [4:0]      rd_p0;
   logic [4:0]      rs1_p0;
   logic [4:0]      rs2_p0;
   logic            legal_p0;
   logic [3:0]      op_p0;
   logic            acc_p0;
   logic [XLEN-1:0] a_p0;
   logic [XLEN-1:0] b_p0;

   logic            vld_p1;
   logic [4:0]      rd_p1;
   logic [3:0]      op_p1;
   logic [XLEN-1:0] a_p1;
   logic [XLEN-1:0] b_p1;
   logic            illegal_p1;

   logic            vld_p2;
   logic [4:0]      rd_p2;
   logic [XLEN-1:0] data_p2;
   logic [31:0]     retired;

   // Returns {legal, op}.
   function automatic logic [4:0] decode(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7);
      logic       legal;
      logic [3:0] op;
      legal = (opc == OPC_OP) &&
              ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      case (f3)
         3'b000:  op = f7[5] ? 4'd1 : 4'd0;
         3'b001:  op = 4'd2;
         3'b010:  op = 4'd3;
         3'b011:  op = 4'd4;
         3'b100:  op = 4'd5;
         3'b101:  op = f7[5] ? 4'd7 : 4'd6;
         3'b110:  op = 4'd8;
         default: op = 4'd9;
      endcase
      return {legal, op};
   endfunction

   // In-flight EX result beats the debug write, which beats the stored register.
   function automatic logic [XLEN-1:0] select_operand(
      input logic [4:0]      rs,
      input logic            ex_vld,
      input logic [4:0]      ex_rd,
      input logic [XLEN-1:0] alu_res,
      input logic            dbg_we,
      input logic [4:0]      dbg_addr,
      input logic [XLEN-1:0] dbg_wdata,
      input logic [XLEN-1:0] rf_val
   );
      if (rs == 5'd0)
         return '0;
      else if (ex_vld && (ex_rd == rs))
         return alu_res;
      else if (dbg_we && (dbg_addr == rs))
         return dbg_wdata;
      else
         return rf_val;
   endfunction

   // p0: decode and operand selection
   always_comb begin
      opc_p0 = bus.i_instr[6:0];
      rd_p0  = bus.i_instr[11:7];
      f3_p0  = bus.i_instr[14:12];
      rs1_p0 = bus.i_instr[19:15];
      rs2_p0 = bus.i_instr[24:20];
      f7_p0  = bus.i_instr[31:25];
      {legal_p0, op_p0} = decode(opc_p0, f3_p0, f7_p0);
      acc_p0 = bus.i_valid && !bus.i_hold;
      a_p0 = select_operand(rs1_p0, vld_p1, rd_p1, bus.i_alu_res, bus.i_dbg_we,
                            bus.i_dbg_addr, bus.i_dbg_wdata, regs[rs1_p0]);
      b_p0 = select_operand(rs2_p0, vld_p1, rd_p1, bus.i_alu_res, bus.i_dbg_we,
                            bus.i_dbg_addr, bus.i_dbg_wdata, regs[rs2_p0]);
   end

   // p1: EX registers; p2: writeback report. Register file updates sit with p2.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         vld_p1     <= 1'b0;
         rd_p1      <= '0;
         op_p1      <= '0;
         a_p1       <= '0;
         b_p1       <= '0;
         illegal_p1 <= 1'b0;
         vld_p2     <= 1'b0;
         rd_p2      <= '0;
         data_p2    <= '0;
         retired    <= '0;
      end else begin
         if (bus.i_dbg_we && (bus.i_dbg_addr != 5'd0))
            regs[bus.i_dbg_addr] <= bus.i_dbg_wdata;
         if (bus.i_hold) begin
            vld_p2     <= 1'b0;
            illegal_p1 <= 1'b0;
         end else begin
            vld_p2     <= vld_p1;
            illegal_p1 <= acc_p0 && !legal_p0;
            if (vld_p1) begin
               // Placed after the debug write so writeback wins on a collision.
               if (rd_p1 != 5'd0) regs[rd_p1] <= bus.i_alu_res;
               rd_p2   <= rd_p1;
               data_p2 <= bus.i_alu_res;
               retired <= retired + 32'd1;
            end
            vld_p1 <= acc_p0 && legal_p0;
            if (acc_p0 && legal_p0) begin
               rd_p1 <= rd_p0;
               op_p1 <= op_p0;
               a_p1  <= a_p0;
               b_p1  <= b_p0;
            end
         end
      end
   end

   assign bus.o_ready     = !bus.i_hold;
   assign bus.o_alu_a     = a_p1;
   assign bus.o_alu_b     = b_p1;
   assign bus.o_alu_op    = op_p1;
   assign bus.o_wb_valid  = vld_p2;
   assign bus.o_wb_rd     = rd_p2;
   assign bus.o_wb_data   = data_p2;
   assign bus.o_illegal   = illegal_p1;
   assign bus.o_retired   = retired;
   assign bus.o_dbg_rdata = (bus.i_dbg_addr == 5'd0) ? '0 : regs[bus.i_dbg_addr];
endmodule

// File: tb/tb_rv_rtype_issue.sv
// Directed bench for rv_rtype_issue: expected writebacks go into a scoreboard queue
// that a negedge monitor drains; ALU operands, flags and registers are checked inline.
module tb_rv_rtype_issue;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;
   wb_t sb[$];

   rv_rtype_issue_if bus ();

   rv_rtype_issue dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU
   always_comb begin
      case (bus.o_alu_op)
         4'd0:    bus.i_alu_res = bus.o_alu_a + bus.o_alu_b;
         4'd1:    bus.i_alu_res = bus.o_alu_a - bus.o_alu_b;
         4'd2:    bus.i_alu_res = bus.o_alu_a << bus.o_alu_b[4:0];
         4'd3:    bus.i_alu_res = {31'd0, $signed(bus.o_alu_a) < $signed(bus.o_alu_b)};
         4'd4:    bus.i_alu_res = {31'd0, bus.o_alu_a < bus.o_alu_b};
         4'd5:    bus.i_alu_res = bus.o_alu_a ^ bus.o_alu_b;
         4'd6:    bus.i_alu_res = bus.o_alu_a >> bus.o_alu_b[4:0];
         4'd7:    bus.i_alu_res = $unsigned($signed(bus.o_alu_a) >>> bus.o_alu_b[4:0]);
         4'd8:    bus.i_alu_res = bus.o_alu_a | bus.o_alu_b;
         4'd9:    bus.i_alu_res = bus.o_alu_a & bus.o_alu_b;
         default: bus.i_alu_res = 32'd0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      wb_t e;
      if (bus.o_wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=0x%h, expected no writeback",
                     bus.o_wb_rd, bus.o_wb_data);
         end else begin
            e = sb.pop_front();
            chk("wb_rd", {27'd0, bus.o_wb_rd}, {27'd0, e.rd});
            chk("wb_data", bus.o_wb_data, e.data);
         end
      end
   end

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dbg_write(input logic [4:0] addr, input logic [31:0] data);
      bus.i_dbg_we    = 1'b1;
      bus.i_dbg_addr  = addr;
      bus.i_dbg_wdata = data;
      tick();
      bus.i_dbg_we = 1'b0;
   endtask

   task automatic reg_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
      bus.i_dbg_addr = addr;
      #1;
      chk(name, bus.o_dbg_rdata, exp);
   endtask

   task automatic issue(input logic [31:0] ins, input logic push, input logic [4:0] rd,
                        input logic [31:0] res);
      if (push) sb.push_back('{rd: rd, data: res});
      bus.i_valid = 1'b1;
      bus.i_instr = ins;
      tick();
   endtask

   task automatic idle();
      bus.i_valid = 1'b0;
      tick();
   endtask

   task automatic alu_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      chk({name, "_op"}, {28'd0, bus.o_alu_op}, {28'd0, op});
      chk({name, "_a"}, bus.o_alu_a, a);
      chk({name, "_b"}, bus.o_alu_b, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst             = 1'b1;
      bus.i_valid     = 1'b0;
      bus.i_instr     = 32'd0;
      bus.i_hold      = 1'b0;
      bus.i_dbg_we    = 1'b0;
      bus.i_dbg_addr  = 5'd0;
      bus.i_dbg_wdata = 32'd0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_wb_valid", {31'd0, bus.o_wb_valid}, 32'd0);
      chk("rst_illegal", {31'd0, bus.o_illegal}, 32'd0);
      chk("rst_retired", bus.o_retired, 32'd0);
      chk("rst_alu_op", {28'd0, bus.o_alu_op}, 32'd0);
      chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);

      // add / sub back-to-back
      dbg_write(5'd1, 32'd5);
      dbg_write(5'd2, 32'd3);
      reg_chk("dbg_x1", 5'd1, 32'd5);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 5'd3, 32'd8);
      alu_chk("add", 4'd0, 32'd5, 32'd3);
      issue(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 1'b1, 5'd4, 32'd2);
      alu_chk("sub", 4'd1, 32'd5, 32'd3);
      chk("add_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);
      idle();
      chk("sub_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);
      idle();
      chk("idle_wb_valid", {31'd0, bus.o_wb_valid}, 32'd0);
      chk("retired_2", bus.o_retired, 32'd2);
      reg_chk("x3", 5'd3, 32'd8);
      reg_chk("x4", 5'd4, 32'd2);

      // Signed / unsigned and logic ops
      dbg_write(5'd1, 32'hFFFF_FFFF);
      dbg_write(5'd2, 32'd1);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd5), 1'b1, 5'd5, 32'd1);
      alu_chk("slt", 4'd3, 32'hFFFF_FFFF, 32'd1);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd6), 1'b1, 5'd6, 32'd0);
      alu_chk("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1);
      issue(rtype(7'h20, 5'd2, 5'd1, 3'b101, 5'd7), 1'b1, 5'd7, 32'hFFFF_FFFF);
      alu_chk("sra", 4'd7, 32'hFFFF_FFFF, 32'd1);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd8), 1'b1, 5'd8, 32'd1);
      alu_chk("and", 4'd9, 32'hFFFF_FFFF, 32'd1);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd9), 1'b1, 5'd9, 32'hFFFF_FFFF);
      alu_chk("or", 4'd8, 32'hFFFF_FFFF, 32'd1);
      idle();
      idle();
      reg_chk("x5_slt", 5'd5, 32'd1);
      reg_chk("x6_sltu", 5'd6, 32'd0);
      reg_chk("x7_sra", 5'd7, 32'hFFFF_FFFF);

      // Debug write bypassed into an operand read in the same cycle
      bus.i_dbg_we    = 1'b1;
      bus.i_dbg_addr  = 5'd10;
      bus.i_dbg_wdata = 32'd7;
      issue(rtype(7'h00, 5'd0, 5'd10, 3'b000, 5'd11), 1'b1, 5'd11, 32'd7);
      bus.i_dbg_we = 1'b0;
      alu_chk("bypass", 4'd0, 32'd7, 32'd0);
      idle();
      idle();
      reg_chk("x11_bypass", 5'd11, 32'd7);

      // Forwarding of an in-flight result
      dbg_write(5'd1, 32'd5);
      dbg_write(5'd2, 32'd3);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 5'd3, 32'd8);
      issue(rtype(7'h00, 5'd3, 5'd3, 3'b000, 5'd4), 1'b1, 5'd4, 32'd16);
      alu_chk("fwd", 4'd0, 32'd8, 32'd8);
      idle();
      idle();
      reg_chk("x4_fwd", 5'd4, 32'd16);
      chk("retired_10", bus.o_retired, 32'd10);

      // Illegal encodings
      issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd12, 7'b0010011}, 1'b0, 5'd0, 32'd0);
      chk("illegal_opcode", {31'd0, bus.o_illegal}, 32'd1);
      issue(rtype(7'h20, 5'd2, 5'd1, 3'b001, 5'd13), 1'b0, 5'd0, 32'd0);
      chk("illegal_funct7", {31'd0, bus.o_illegal}, 32'd1);
      idle();
      chk("illegal_clear", {31'd0, bus.o_illegal}, 32'd0);
      idle();
      chk("illegal_retired", bus.o_retired, 32'd10);
      reg_chk("x12_untouched", 5'd12, 32'd0);
      reg_chk("x13_untouched", 5'd13, 32'd0);

      // Hold freezes EX for three cycles
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 1'b1, 5'd14, 32'd8);
      bus.i_valid = 1'b0;
      bus.i_hold  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_ready", {31'd0, bus.o_ready}, 32'd0);
         chk("hold_wb_valid", {31'd0, bus.o_wb_valid}, 32'd0);
         alu_chk("hold", 4'd0, 32'd5, 32'd3);
      end
      bus.i_hold = 1'b0;
      tick();
      chk("release_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);
      chk("release_wb_rd", {27'd0, bus.o_wb_rd}, 32'd14);
      chk("release_retired", bus.o_retired, 32'd11);

      // rd = x0, then reset discards an in-flight instruction
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 1'b1, 5'd0, 32'd8);
      idle();
      reg_chk("x0_zero", 5'd0, 32'd0);
      chk("x0_retired", bus.o_retired, 32'd12);
      issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd16), 1'b0, 5'd0, 32'd0);
      bus.i_valid = 1'b0;
      rst         = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("post_rst_wb_valid", {31'd0, bus.o_wb_valid}, 32'd0);
      chk("post_rst_retired", bus.o_retired, 32'd0);
      chk("post_rst_alu_a", bus.o_alu_a, 32'd0);
      reg_chk("post_rst_x1", 5'd1, 32'd0);
      reg_chk("post_rst_x16", 5'd16, 32'd0);
      idle();
      idle();
      chk("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
